mcu_pixel_ingest: RTL and testbench
===================================

# mcu_pixel_ingest

- Upstream stage of the dithering pipeline: accepts the image byte stream from the MCU over a valid/ready handshake and writes one 8-bit pixel per SRAM word, in raster order, through SRAM port A.
- Optionally converts each RGB triplet to 8-bit luma before the write.
- Signals frame completion to the dithering loop controller, which then begins error-diffusion passes over the stored frame.

## Interface
Parameters:
- IMAGEX, 64, image width in pixels
- IMAGEY, 64, image height in pixels
- IMAGE_SIZE, IMAGEX*IMAGEY, pixels per frame
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), SRAM address width
- RGB_SIZE, 8, bits per channel and per stored pixel

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  arm for a new frame (sampled in IDLE only)
- mcu_valid  in  1  MCU byte valid
- mcu_data  in  RGB_SIZE  MCU byte
- mcu_ready  out  1  block can accept a byte
- sram_wren  out  1  port-A write enable
- sram_addr  out  IMAGE_ADDR_WIDTH  port-A address
- sram_data  out  RGB_SIZE  port-A write data
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel write

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: mcu_ready=0; bytes are ignored.
  - start=1 → RECV next cycle.
  - Clears pix_idx and chan_cnt.
- RECV: mcu_ready=1.
  - A byte is accepted when mcu_valid && mcu_ready.
  - With GRAYSCALE_CONV_EN, bytes arrive as R, G, B.
  - chan_cnt counts 0→1→2; each accepted byte adds weight×byte into a 16-bit accumulator. Weights: R=77, G=150, B=29 (sum 256).
  - On the byte where chan_cnt==2: result = acc[15:8] is registered, chan_cnt→0, state → WRITE.
- WRITE: mcu_ready=0; sram_wren=1 for exactly one cycle.
  - sram_addr=pix_idx, sram_data=result.
  - If pix_idx==IMAGE_SIZE-1 → DONE; else pix_idx+1 → RECV.
- DONE: frame_done=1 for one cycle; pix_idx clears → IDLE.
- Arithmetic: max acc = 255·256 = 65280, which fits 16 bits with no saturation.
  - Pure white (255,255,255) → 255; black → 0.
- start is ignored outside IDLE.
- Bytes beyond IMAGE_SIZE pixels are not accepted, because ready=0 in DONE/IDLE.
- mcu_valid may drop mid-triplet; partial accumulation is held indefinitely.

## Timing
- Reset values: mcu_ready=0, sram_wren=0, sram_addr=0, sram_data=0, busy=0, frame_done=0, state=IDLE, pix_idx=0, chan_cnt=0, acc=0.
- rst_n low mid-frame: next edge forces IDLE and discards any partial pixel; no write is issued on that edge.
- All outputs are registered or decoded from state only; mcu_ready has no combinational path from mcu_valid.
- Latency: last byte of a pixel accepted at edge N → sram_wren high during cycle N+1 → address/data stable for that whole cycle.
- Minimum throughput, conversion on: 4 cycles/pixel. Conversion off: 2 cycles/pixel.
- frame_done is asserted in the cycle after the final write; busy falls the cycle after that.

## Configuration
- GRAYSCALE_CONV_EN defined:
  - three bytes per pixel, luma conversion as above;
  - accumulator and multipliers are present.
- GRAYSCALE_CONV_EN undefined:
  - one byte per pixel;
  - result = accepted byte unchanged, so every accepted byte goes RECV → WRITE;
  - chan_cnt and accumulator are compiled out.

## Structure
- Shared package dither_pkg holds:
  - the ingest state enum;
  - luma weight constants LUMA_W_R/G/B;
  - the accumulator width constant LUMA_ACC_W=16.
- One sub-module, luma_accumulator: clears, takes byte + chan_cnt + accept, outputs acc[15:8]. It is instantiated only under GRAYSCALE_CONV_EN.

## Test plan
- Reset, then start with conversion on; stream (255,255,255),(0,0,0),(100,50,200) → writes addr0=255, addr1=0, addr2=(7700+7500+5800)>>8=82.
- Full 64×64 frame with continuous valid → exactly 4096 sram_wren pulses, addresses 0..4095 in order, and one frame_done pulse one cycle after addr 4095.
- Random mcu_valid gaps, including mid-triplet → same data as the gapless run; no write is issued until the third byte is accepted.
- rst_n low after 2 bytes of pixel 10 → IDLE, no write; after a new start, first write goes to addr 0.
- mcu_valid high in IDLE, or start pulsed during RECV → mcu_ready stays 0 in IDLE, and the frame is unaffected.
- GRAYSCALE_CONV_EN undefined; bytes 0x12, 0xAB → addr0=0x12, addr1=0xAB at 2 cycles/pixel.

Source files
------------

// File: rtl/dither_pkg.sv
// dither_pkg: shared ingest state encoding and luma constants for the dithering pipeline
package dither_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_WRITE, ST_DONE} ingest_state_e;
  localparam int LUMA_ACC_W = 16;
  localparam logic [7:0] LUMA_W_R = 8'd77;
  localparam logic [7:0] LUMA_W_G = 8'd150;
  localparam logic [7:0] LUMA_W_B = 8'd29;
  function automatic logic [7:0] luma_weight(input logic [1:0] chan);
    return chan == 2'd0 ? LUMA_W_R : chan == 2'd1 ? LUMA_W_G : LUMA_W_B;
  endfunction
endpackage

// File: rtl/luma_accumulator.sv
// luma_accumulator: weighted R,G,B sum; luma is the high byte of the running sum including the current byte
module luma_accumulator
  import dither_pkg::*;
#(
  parameter int RGB_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                accept,
  input  logic [1:0]          chan_cnt,
  input  logic [RGB_SIZE-1:0] byte_in,
  output logic [RGB_SIZE-1:0] luma
);
  logic [LUMA_ACC_W-1:0] acc_q, acc_d, acc_sum;
  always_comb begin
    acc_sum = acc_q + LUMA_ACC_W'(luma_weight(chan_cnt)) * LUMA_ACC_W'(byte_in);
    acc_d = clr ? '0 : !accept ? acc_q : chan_cnt == 2'd2 ? '0 : acc_sum;
  end
  assign luma = acc_sum[LUMA_ACC_W-1 -: RGB_SIZE];
  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/mcu_pixel_ingest.sv
// mcu_pixel_ingest: MCU byte stream to one-pixel-per-word SRAM writes in raster order.
// GRAYSCALE_CONV_EN: three bytes (R,G,B) per pixel reduced to 8-bit luma; otherwise one byte per pixel.
module mcu_pixel_ingest
  import dither_pkg::*;
#(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mcu_valid,
  input  logic [RGB_SIZE-1:0]         mcu_data,
  output logic                        mcu_ready,
  output logic                        sram_wren,
  output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
  output logic [RGB_SIZE-1:0]         sram_data,
  output logic                        busy,
  output logic                        frame_done
);
  ingest_state_e state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] pix_idx_q, pix_idx_d;
  logic [RGB_SIZE-1:0] result_q, result_d, pix_val;
  logic accept, last_byte;
  assign accept = mcu_valid && state_q == ST_RECV;
`ifdef GRAYSCALE_CONV_EN
  logic [1:0] chan_cnt_q, chan_cnt_d;
  luma_accumulator #(.RGB_SIZE(RGB_SIZE)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_IDLE),
    .accept   (accept),
    .chan_cnt (chan_cnt_q),
    .byte_in  (mcu_data),
    .luma     (pix_val)
  );
  assign last_byte = chan_cnt_q == 2'd2;
  always_comb chan_cnt_d = state_q == ST_IDLE ? 2'd0 : !accept ? chan_cnt_q : last_byte ? 2'd0 : chan_cnt_q + 2'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) chan_cnt_q <= 2'd0;
    else chan_cnt_q <= chan_cnt_d;
  end
`else
  assign last_byte = 1'b1;
  assign pix_val = mcu_data;
`endif
  always_comb begin
    state_d = state_q;
    pix_idx_d = pix_idx_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        pix_idx_d = '0;
        if (start) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (accept && last_byte) begin
          result_d = pix_val;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (pix_idx_q == IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1)) state_d = ST_DONE;
        else begin
          pix_idx_d = pix_idx_q + IMAGE_ADDR_WIDTH'(1);
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        pix_idx_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pix_idx_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      pix_idx_q <= pix_idx_d;
      result_q <= result_d;
    end
  end
  assign mcu_ready = state_q == ST_RECV;
  assign sram_wren = state_q == ST_WRITE;
  assign sram_addr = pix_idx_q;
  assign sram_data = result_q;
  assign busy = state_q != ST_IDLE;
  assign frame_done = state_q == ST_DONE;
endmodule

// File: tb/tb_mcu_pixel_ingest.sv
// tb_mcu_pixel_ingest: table vectors, reset/idle corner sequences and two full random frames against a luma model
module tb_mcu_pixel_ingest;
  localparam int IMAGE_SIZE = 4096;
`ifdef GRAYSCALE_CONV_EN
  localparam int BPP = 3;
  localparam int NV = 6;
`else
  localparam int BPP = 1;
  localparam int NV = 4;
`endif
  typedef struct {
    logic [7:0] r, g, b, y;
  } vec_t;

  logic clk = 0, rst_n = 0, start = 0, mcu_valid = 0;
  logic [7:0] mcu_data = 0;
  logic mcu_ready, sram_wren, busy, frame_done;
  logic [11:0] sram_addr;
  logic [7:0] sram_data;

  mcu_pixel_ingest dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcu_valid(mcu_valid), .mcu_data(mcu_data),
    .mcu_ready(mcu_ready), .sram_wren(sram_wren), .sram_addr(sram_addr), .sram_data(sram_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, nacc = 0, bad_ready = 0;
  logic busy_prev = 0;
  int wa[$], wd[$], wc[$], pc[$], dc[$], bf[$];
  logic [7:0] mem [IMAGE_SIZE*3];
  vec_t tbl [NV];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    busy_prev <= busy;
    if (!rst_n) nacc <= 0;
    else if (mcu_valid && mcu_ready) begin
      if (nacc == BPP - 1) begin
        pc.push_back(cyc);
        nacc <= 0;
      end else nacc <= nacc + 1;
    end
    if (sram_wren) begin
      wa.push_back(int'(sram_addr));
      wd.push_back(int'(sram_data));
      wc.push_back(cyc);
    end
    if (frame_done) dc.push_back(cyc);
    if (busy_prev && !busy) bf.push_back(cyc);
    if (mcu_ready && !busy) bad_ready <= bad_ready + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wa.delete(); wd.delete(); wc.delete(); pc.delete(); dc.delete(); bf.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    start = gaps && ($urandom_range(0, 7) == 0);
    mcu_valid = 1;
    mcu_data = b;
    @(negedge clk);
    while (!mcu_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!mcu_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready stayed 0 for %0d cycles", n);
    end
    tick();
    mcu_valid = 0;
    start = 0;
  endtask

  task automatic send_vec(input int k);
    send(tbl[k].r, 0);
    if (BPP == 3) begin
      send(tbl[k].g, 0);
      send(tbl[k].b, 0);
    end
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wa.size() < n && t < 50) begin
      tick();
      t++;
    end
  endtask

  function automatic int ref_pix(input int i);
    if (BPP == 3) return (77 * int'(mem[3*i]) + 150 * int'(mem[3*i+1]) + 29 * int'(mem[3*i+2])) / 256;
    return int'(mem[i]);
  endfunction

  task automatic run_frame(input bit gaps);
    int t = 0, bad_a = 0, bad_d = 0, bad_l = 0, bad_s = 0, last;
    clear_q();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < IMAGE_SIZE * BPP; i++) send(mem[i], gaps);
    while (dc.size() == 0 && t < 20) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk(gaps ? "gap_frame_writes" : "frame_writes", wa.size(), IMAGE_SIZE);
    for (int i = 0; i < wa.size() && i < IMAGE_SIZE; i++) begin
      if (wa[i] != i) bad_a++;
      if (wd[i] != ref_pix(i)) bad_d++;
      if (i >= pc.size() || wc[i] != pc[i] + 1) bad_l++;
      if (i > 0 && wc[i] - wc[i-1] != BPP + 1) bad_s++;
    end
    chk(gaps ? "gap_frame_addr_order" : "frame_addr_order", bad_a, 0);
    chk(gaps ? "gap_frame_data" : "frame_data", bad_d, 0);
    chk(gaps ? "gap_frame_write_latency" : "frame_write_latency", bad_l, 0);
    if (!gaps) chk("frame_cycles_per_pixel", bad_s, 0);
    last = wa.size() > 0 ? wc[wa.size()-1] : -100;
    chk("frame_done_pulses", dc.size(), 1);
    chk("frame_done_after_last_write", dc.size() > 0 ? dc[0] - last : -1, 1);
    chk("busy_fall_after_done", (bf.size() > 0 && dc.size() > 0) ? bf[0] - dc[0] : -1, 1);
  endtask

  initial begin
`ifdef GRAYSCALE_CONV_EN
    tbl[0] = '{8'd255, 8'd255, 8'd255, 8'd255};
    tbl[1] = '{8'd0, 8'd0, 8'd0, 8'd0};
    tbl[2] = '{8'd100, 8'd50, 8'd200, 8'd82};
    tbl[3] = '{8'd255, 8'd0, 8'd0, 8'd76};
    tbl[4] = '{8'd0, 8'd255, 8'd0, 8'd149};
    tbl[5] = '{8'd0, 8'd0, 8'd255, 8'd28};
`else
    tbl[0] = '{8'h12, 8'h00, 8'h00, 8'h12};
    tbl[1] = '{8'hAB, 8'h00, 8'h00, 8'hAB};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
`endif
    repeat (3) tick();
    chk("rst_mcu_ready", mcu_ready, 0);
    chk("rst_sram_wren", sram_wren, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_data", sram_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1;
    tick();
    chk("idle_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
    chk("recv_busy", busy, 1);
    chk("recv_ready", mcu_ready, 1);

    clear_q();
    for (int k = 0; k < NV; k++) send_vec(k);
    wait_writes(NV);
    chk("vec_writes", wa.size(), NV);
    for (int k = 0; k < NV && k < wa.size(); k++) begin
      chk($sformatf("vec%0d_addr", k), wa[k], k);
      chk($sformatf("vec%0d_data", k), wd[k], int'(tbl[k].y));
      chk($sformatf("vec%0d_latency", k), k < pc.size() ? wc[k] - pc[k] : -1, 1);
      if (k > 0) chk($sformatf("vec%0d_spacing", k), wc[k] - wc[k-1], BPP + 1);
    end

    for (int p = NV; p < 10; p++) repeat (BPP) send(8'($urandom), 0);
    wait_writes(10);
    chk("pre_reset_writes", wa.size(), 10);
    repeat (BPP - 1) send(8'($urandom), 0);
    mcu_valid = 1;
    mcu_data = 8'($urandom);
    rst_n = 0;
    tick();
    tick();
    chk("reset_no_write", wa.size(), 10);
    chk("reset_busy", busy, 0);
    chk("reset_ready", mcu_ready, 0);
    chk("reset_wren", sram_wren, 0);
    rst_n = 1;
    repeat (4) tick();
    chk("idle_valid_ready", mcu_ready, 0);
    chk("idle_valid_no_write", wa.size(), 10);
    chk("idle_valid_busy", busy, 0);
    mcu_valid = 0;
    start = 1;
    tick();
    start = 0;
    send_vec(0);
    wait_writes(11);
    chk("post_reset_addr", wa.size() > 10 ? wa[10] : -1, 0);
    chk("post_reset_data", wa.size() > 10 ? wd[10] : -1, int'(tbl[0].y));
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < IMAGE_SIZE * BPP; i++) mem[i] = 8'($urandom);
    run_frame(0);
    run_frame(1);
    chk("ready_only_when_busy", bad_ready, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
